// File: rtl/future_pkg.sv
// FUTURE cipher shared constants, types and round primitives.
// Used by both the encryption datapath and the decryption core.
package future_pkg;

  localparam int NR = 10;

  typedef logic [0:63] block_t;
  typedef logic [3:0]  nib_t;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  localparam logic [0:15][3:0] SBOX = {
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  localparam logic [0:15][3:0] INV_SBOX = {
    4'h5, 4'hE, 4'hF, 4'h8, 4'hC, 4'h1, 4'h2, 4'hD,
    4'hB, 4'h4, 4'h6, 4'h3, 4'h0, 4'h7, 4'h9, 4'hA
  };

  // Hadamard row with XOR-sum 1: the matrix is its own inverse
  localparam logic [0:3][3:0] INV_MC = {
    4'h1, 4'h4, 4'h9, 4'hD
  };

  localparam logic [0:10][0:63] RC = {
    64'h0000000000000000,
    64'h243F6A8885A308D3,
    64'h13198A2E03707344,
    64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89,
    64'h452821E638D01377,
    64'hBE5466CF34E90C6C,
    64'hC0AC29B7C97C50DD,
    64'h3F84D5B5B5470917,
    64'h9216D5D98979FB1B,
    64'hD1310BA698DFB5AC
  };

  // GF(2^4) multiply modulo x^4 + x + 1
  function automatic nib_t gmul(nib_t a, nib_t b);
    logic [6:0] p;
    p = '0;
    for (int i = 0; i < 4; i++)
      if (b[i]) p = p ^ ({3'b000, a} << i);
    for (int i = 6; i >= 4; i--)
      if (p[i]) p = p ^ (7'h13 << (i - 4));
    return p[3:0];
  endfunction

  function automatic block_t mix_cols(block_t s);
    block_t o;
    nib_t   acc;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      for (int i = 0; i < 4; i++) begin
        acc = '0;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(INV_MC[i ^ j], s[16*c+4*j +: 4]);
        o[16*c+4*i +: 4] = acc;
      end
    end
    return o;
  endfunction

  function automatic block_t inv_mix(block_t s);
    return mix_cols(s);
  endfunction

  function automatic block_t shift_rows(block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[16*c+4*r +: 4] = s[16*((c+r)%4)+4*r +: 4];
    return o;
  endfunction

  function automatic block_t inv_shift(block_t s);
    block_t o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[16*c+4*r +: 4] = s[16*((c-r+4)%4)+4*r +: 4];
    return o;
  endfunction

  function automatic block_t sub_nib(block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[4*i +: 4] = SBOX[s[4*i +: 4]];
    return o;
  endfunction

  function automatic block_t inv_sub(block_t s);
    block_t o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[4*i +: 4] = INV_SBOX[s[4*i +: 4]];
    return o;
  endfunction

  function automatic block_t rotl(block_t x, logic [5:0] n);
    return (x << n) | (x >> (7'd64 - {1'b0, n}));
  endfunction

  // Even rounds rotate K0, odd rounds K1, by 5 bits per key pair
  function automatic block_t round_key(
    block_t k0, block_t k1, logic [3:0] r
  );
    logic [5:0] n;
    n = {3'b000, r[3:1]} * 6'd5;
    return r[0] ? rotl(k1, n) : rotl(k0, n);
  endfunction

endpackage

// File: rtl/future_inv_round.sv
// One combinational FUTURE inverse round:
// InvSB(InvSR(mc_en ? InvMC(s^rk^rc) : s^rk^rc)).
module future_inv_round
  import future_pkg::*;
(
  input  block_t s,
  input  block_t rk,
  input  block_t rc,
  input  logic   mc_en,
  output block_t y
);

  block_t x;
  block_t m;

  assign x = s ^ rk ^ rc;
  assign m = mc_en ? inv_mix(x) : x;
  assign y = inv_sub(inv_shift(m));

endmodule

// File: rtl/future_dec_core.sv
// Iterative FUTURE decryption core, one inverse round per cycle,
// valid/ready handshakes on ciphertext input and plaintext output.
module future_dec_core #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:63]  ct_in,
  input  logic [0:127] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:63]  pt_out,
  output logic         busy
);

  import future_pkg::*;

  localparam logic [3:0] R_LAST = 4'(NR);

  state_e     state;
  block_t     s_q;
  block_t     k0_q;
  block_t     k1_q;
  logic [3:0] rnd;

  logic       idle;
  block_t     k0_src;
  block_t     k1_src;
  block_t     s_src;
  block_t     rk;
  block_t     rc;
  block_t     y;
  logic [3:0] r_idx;

  assign idle = (state == IDLE);

  // In IDLE the first step runs straight off the input bus
  always_comb begin
    k0_src = idle ? key_in[0:63]   : k0_q;
    k1_src = idle ? key_in[64:127] : k1_q;
    s_src  = idle ? ct_in : s_q;
    r_idx  = idle ? R_LAST : rnd;
    rk     = round_key(k0_src, k1_src, r_idx);
    rc     = RC[r_idx];
  end

  future_inv_round u_round (
    .s     (s_src),
    .rk    (rk),
    .rc    (rc),
    .mc_en (!idle),
    .y     (y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s_q       <= '0;
      k0_q      <= '0;
      k1_q      <= '0;
      rnd       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      pt_out    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            k0_q     <= key_in[0:63];
            k1_q     <= key_in[64:127];
            s_q      <= y;
            rnd      <= R_LAST - 4'd1;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ROUND;
          end
        end
        ROUND: begin
          s_q <= y;
          rnd <= rnd - 4'd1;
          if (rnd == 4'd1)
            state <= FINAL;
        end
        FINAL: begin
          pt_out    <= s_q ^ k0_q;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_future_dec_core.sv
// Bench for future_dec_core: forward-cipher reference model,
// per-cycle protocol model and directed scenarios.
module tb_future_dec_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:63]  ct_in = '0;
  logic [0:127] key_in = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [0:63]  pt_out;
  logic         busy;

  future_dec_core #(.NR(10)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ct_in     (ct_in),
    .key_in    (key_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pt_out    (pt_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference cipher ----------------
  localparam logic [3:0] SB [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
  localparam logic [3:0] H [4] = '{4'h1, 4'h4, 4'h9, 4'hD};
  localparam logic [63:0] RCB [11] = '{
    64'h0000000000000000, 64'h243F6A8885A308D3,
    64'h13198A2E03707344, 64'hA4093822299F31D0,
    64'h082EFA98EC4E6C89, 64'h452821E638D01377,
    64'hBE5466CF34E90C6C, 64'hC0AC29B7C97C50DD,
    64'h3F84D5B5B5470917, 64'h9216D5D98979FB1B,
    64'hD1310BA698DFB5AC};

  function automatic logic [3:0] nib(logic [63:0] s, int i);
    return s[63-4*i -: 4];
  endfunction

  function automatic logic [3:0] xt(logic [3:0] x);
    return {x[2:0], 1'b0} ^ (x[3] ? 4'h3 : 4'h0);
  endfunction

  function automatic logic [3:0] gm(logic [3:0] a, logic [3:0] b);
    logic [3:0] r = 4'h0;
    for (int i = 3; i >= 0; i--)
      r = xt(r) ^ (b[i] ? a : 4'h0);
    return r;
  endfunction

  function automatic logic [63:0] sbf(logic [63:0] x, bit inv);
    logic [63:0] o = '0;
    for (int i = 0; i < 16; i++) begin
      if (!inv) o[63-4*i -: 4] = SB[nib(x, i)];
      else
        for (int v = 0; v < 16; v++)
          if (SB[v] == nib(x, i)) o[63-4*i -: 4] = 4'(v);
    end
    return o;
  endfunction

  function automatic logic [63:0] srf(logic [63:0] x, bit inv);
    logic [63:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[63-4*(4*c+r) -: 4] = inv ?
          nib(x, 4*((c-r+4)%4)+r) : nib(x, 4*((c+r)%4)+r);
    return o;
  endfunction

  function automatic logic [63:0] mcf(logic [63:0] x);
    logic [63:0] o = '0;
    logic [3:0] acc;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) begin
        acc = 4'h0;
        for (int j = 0; j < 4; j++)
          acc ^= gm(H[i ^ j], nib(x, 4*c+j));
        o[63-4*(4*c+i) -: 4] = acc;
      end
    return o;
  endfunction

  function automatic logic [63:0] rot(logic [63:0] x, int n);
    if (n == 0) return x;
    return (x << n) | (x >> (64 - n));
  endfunction

  function automatic logic [63:0] rkf(logic [127:0] k, int r);
    if (r % 2 == 0) return rot(k[127:64], 5 * (r / 2));
    return rot(k[63:0], 5 * ((r - 1) / 2));
  endfunction

  function automatic logic [63:0] enc(logic [63:0] p, logic [127:0] k);
    logic [63:0] s = p ^ rkf(k, 0);
    for (int r = 1; r <= 9; r++)
      s = mcf(srf(sbf(s, 0), 0)) ^ rkf(k, r) ^ RCB[r];
    return srf(sbf(s, 0), 0) ^ rkf(k, 10) ^ RCB[10];
  endfunction

  function automatic logic [63:0] dec(logic [63:0] c, logic [127:0] k);
    logic [63:0] s = sbf(srf(c ^ rkf(k, 10) ^ RCB[10], 1), 1);
    for (int r = 9; r >= 1; r--)
      s = sbf(srf(mcf(s ^ rkf(k, r) ^ RCB[r]), 1), 1);
    return s ^ rkf(k, 0);
  endfunction

  // ---------------- protocol model ----------------
  int          age = -1;
  logic        m_ov = 1'b0;
  logic [63:0] m_pt = '0;
  logic [63:0] pend = '0;
  logic [63:0] cur_pt = '0;
  int          dut_acc = 0;
  int          dut_xfer = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      age  <= -1;
      m_ov <= 1'b0;
      m_pt <= '0;
    end else if (age < 0) begin
      if (in_valid) begin
        age  <= 0;
        pend <= cur_pt;
      end
    end else if (age < 10) begin
      age <= age + 1;
      if (age == 9) begin
        m_ov <= 1'b1;
        m_pt <= pend;
      end
    end else if (out_ready) begin
      m_ov <= 1'b0;
      age  <= -1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(in_ready), 64'(age < 0));
      chk("out_valid", 64'(out_valid), 64'(m_ov));
      chk("busy", 64'(busy), 64'(age >= 0 && age < 10));
      chk("pt_out", pt_out, m_pt);
      if (in_valid && in_ready) dut_acc++;
      if (out_valid && out_ready) dut_xfer++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_ready();
    int w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_timeout", 64'(in_ready), 64'd1);
  endtask

  task automatic send(logic [63:0] ct, logic [63:0] pt, logic [127:0] k);
    wait_ready();
    in_valid = 1'b1;
    ct_in    = ct;
    key_in   = k;
    cur_pt   = pt;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_ov(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  localparam logic [127:0] KA = 128'h0123456789ABCDEF_FEDCBA9876543210;

  initial begin
    logic [63:0] p, c, x;
    logic [127:0] kf;
    int n, a0, x0;
    bit saw;

    // reference model pins
    chk("gm_2x8", 64'(gm(4'h2, 4'h8)), 64'h3);
    chk("rot4", rot(64'h0123456789ABCDEF, 4), 64'h123456789ABCDEF0);
    chk("sr_ref", srf(64'h0123456789ABCDEF, 0), 64'h05AF49E38D27C16B);
    chk("mc_col0", mcf(64'h1000_0000_0000_0000), 64'h149D_0000_0000_0000);
    chk("rk10_rot25", rkf({64'h8000000000000000, 64'h0}, 10),
        64'h0000000001000000);
    chk("rk9_rot20", rkf({64'h0, 64'h1}, 9), 64'h0000000000100000);
    x = 64'hDEADBEEF01234567;
    chk("mc_invol", mcf(mcf(x)), x);
    chk("enc_dec", enc(dec(x, KA), KA), x);

    // reset
    #1 rst_n = 1'b0;
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pt", pt_out, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // all-zero key and plaintext, latency
    send(enc(64'h0, 128'h0), 64'h0, 128'h0);
    wait_ov(n);
    chk("latency", 64'(n), 64'd10);
    chk("zero_pt", pt_out, 64'h0);
    @(posedge clk); #1;

    // abort mid-ROUND by reset
    p = 64'h0011223344556677;
    send(enc(p, KA), p, KA);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_out_valid", 64'(out_valid), 64'd0);
    chk("abort_pt", pt_out, 64'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      saw |= out_valid;
    end
    chk("abort_no_ov", 64'(saw), 64'd0);

    // output stall with ignored input pulses
    out_ready = 1'b0;
    p = 64'hCAFEF00D12345678;
    @(posedge clk); #1;
    send(enc(p, KA), p, KA);
    wait_ov(n);
    chk("stall_latency", 64'(n), 64'd10);
    repeat (10) begin
      in_valid = 1'b1;
      ct_in    = {$urandom, $urandom};
      cur_pt   = {$urandom, $urandom};
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
    end
    chk("stall_pt", pt_out, p);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_in_ready", 64'(in_ready), 64'd1);

    // in_valid held high with new data every cycle
    a0 = dut_acc;
    in_valid = 1'b1;
    for (int k = 0; k < 62; k++) begin
      p      = {$urandom, $urandom};
      ct_in  = enc(p, KA);
      key_in = KA;
      cur_pt = p;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_ready();
    chk("stream_accepts", 64'(dut_acc - a0), 64'd6);

    // all-ones key and ciphertext
    kf = '1;
    c  = '1;
    send(c, dec(c, kf), kf);
    wait_ov(n);
    chk("ones_pt", pt_out, dec(c, kf));
    @(posedge clk); #1;

    // random plaintexts under a fixed key
    x0 = dut_xfer;
    for (int i = 0; i < 1000; i++) begin
      p = {$urandom, $urandom};
      send(enc(p, KA), p, KA);
    end
    wait_ready();
    chk("random_xfers", 64'(dut_xfer - x0), 64'd1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
